// File: rtl/router_psum_pkg.sv
// Shared types for the psum router: FSM state encoding and the psum word type.
package router_psum_pkg;

    localparam int PSUM_W = 16;

    typedef logic [PSUM_W-1:0] psum_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/router_psum_if.sv
// Bundle between PE cluster, psum router and psum GLB bank.
// The slave modport is the router's view; master is the surrounding system.
interface router_psum_if #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int X_dim             = 3
);
    logic [X_dim-1:0][DATA_BITWIDTH-1:0] pe_out;
    logic                                compute_done;
    logic                                accum_first;

    logic                                write_en_glb_psum;
    logic [ADDR_BITWIDTH_GLB-1:0]        w_addr_glb_psum;
    logic [DATA_BITWIDTH-1:0]            w_data_glb_psum;
    logic                                read_req_glb_psum;
    logic [ADDR_BITWIDTH_GLB-1:0]        r_addr_glb_psum;
    logic [DATA_BITWIDTH-1:0]            r_data_glb_psum;

    logic                                busy;
    logic                                write_done;
    logic                                drop_err;

    modport master (
        output pe_out, compute_done, accum_first, r_data_glb_psum,
        input  write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum,
        input  read_req_glb_psum, r_addr_glb_psum,
        input  busy, write_done, drop_err
    );

    modport slave (
        input  pe_out, compute_done, accum_first, r_data_glb_psum,
        output write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum,
        output read_req_glb_psum, r_addr_glb_psum,
        output busy, write_done, drop_err
    );
endinterface

// File: rtl/psum_capture_buf.sv
// Column buffer: all X_dim psums are loaded together on capture and read back
// one column at a time while the router walks the row.
module psum_capture_buf #(
    parameter int DATA_BITWIDTH = 16,
    parameter int X_dim         = 3,
    parameter int IDX_W         = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                load,
    input  logic [X_dim-1:0][DATA_BITWIDTH-1:0] din,
    input  logic [IDX_W-1:0]                    rd_idx,
    output logic [DATA_BITWIDTH-1:0]            rd_data
);

    logic [X_dim-1:0][DATA_BITWIDTH-1:0] entries;

    for (genvar gi = 0; gi < X_dim; gi++) begin : g_entry
        logic [DATA_BITWIDTH-1:0] entry_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                entry_reg <= '0;
            end else if (load) begin
                entry_reg <= din[gi];
            end
        end

        assign entries[gi] = entry_reg;
    end

    assign rd_data = entries[rd_idx];

endmodule

// File: rtl/router_psum.sv
// Writes one row of PE column psums into the psum GLB per compute iteration.
// Define ROUTER_PSUM_ACCUM_EN to compile in read-modify-write accumulation.
module router_psum
    import router_psum_pkg::*;
#(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int X_dim             = 3,
    parameter int NUM_ITER          = 3,
    parameter int PSUM_LOAD_ADDR    = 0
) (
    input  logic          clk,
    input  logic          reset,
    router_psum_if.slave  bus
);

    localparam int COL_W  = (X_dim > 1)    ? $clog2(X_dim)    : 1;
    localparam int ITER_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_WRITE = WRITE;
    localparam logic [2:0] ST_DONE  = DONE;
`ifdef ROUTER_PSUM_ACCUM_EN
    localparam logic [2:0] ST_READ  = READ;
    localparam logic [2:0] ST_WAIT  = WAIT;
    localparam logic [2:0] ST_FIRST = READ;
`else
    localparam logic [2:0] ST_FIRST = WRITE;
`endif

    logic [2:0]                   state_reg, state_next;
    logic [COL_W-1:0]             col_reg, col_next;
    logic [ITER_W-1:0]            iter_reg, iter_next;
    logic                         cd_prev_reg;
    logic                         drop_err_reg;
    logic                         cd_rise;
    logic                         load;
    logic                         last_col;
    logic                         last_iter;
    logic [DATA_BITWIDTH-1:0]     buf_data;
    logic [ADDR_BITWIDTH_GLB-1:0] col_addr;

    assign cd_rise   = bus.compute_done & ~cd_prev_reg;
    assign load      = cd_rise && (state_reg == ST_IDLE);
    assign last_col  = (col_reg == COL_W'(X_dim - 1));
    assign last_iter = (iter_reg == ITER_W'(NUM_ITER - 1));

    // Modular address arithmetic gives the required truncation for free.
    assign col_addr = ADDR_BITWIDTH_GLB'(PSUM_LOAD_ADDR)
                    + ADDR_BITWIDTH_GLB'(iter_reg) * ADDR_BITWIDTH_GLB'(X_dim)
                    + ADDR_BITWIDTH_GLB'(col_reg);

    psum_capture_buf #(
        .DATA_BITWIDTH (DATA_BITWIDTH),
        .X_dim         (X_dim),
        .IDX_W         (COL_W)
    ) u_capture_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .din     (bus.pe_out),
        .rd_idx  (col_reg),
        .rd_data (buf_data)
    );

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        iter_next  = iter_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load) begin
                    state_next = ST_FIRST;
                    col_next   = '0;
                end
            end
`ifdef ROUTER_PSUM_ACCUM_EN
            ST_READ:  state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_WRITE;
`endif
            ST_WRITE: begin
                if (last_col) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_FIRST;
                    col_next   = col_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                iter_next  = last_iter ? '0 : iter_reg + 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            col_reg      <= '0;
            iter_reg     <= '0;
            cd_prev_reg  <= 1'b0;
            drop_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            col_reg     <= col_next;
            iter_reg    <= iter_next;
            cd_prev_reg <= bus.compute_done;
            // An edge arriving mid-sequence is lost; remember that it happened.
            if (cd_rise && (state_reg != ST_IDLE)) begin
                drop_err_reg <= 1'b1;
            end
        end
    end

    assign bus.write_en_glb_psum = (state_reg == ST_WRITE);
    assign bus.w_addr_glb_psum   = bus.write_en_glb_psum ? col_addr : '0;
    assign bus.busy              = (state_reg != ST_IDLE);
    assign bus.write_done        = (state_reg == ST_DONE);
    assign bus.drop_err          = drop_err_reg;

`ifdef ROUTER_PSUM_ACCUM_EN
    logic                     accum_first_reg;
    logic [DATA_BITWIDTH-1:0] sum_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accum_first_reg <= 1'b0;
            sum_reg         <= '0;
        end else begin
            if (load) begin
                accum_first_reg <= bus.accum_first;
            end
            // GLB read data is valid in WAIT, one cycle after the request.
            if (state_reg == ST_WAIT) begin
                sum_reg <= bus.r_data_glb_psum + buf_data;
            end
        end
    end

    assign bus.read_req_glb_psum = (state_reg == ST_READ);
    assign bus.r_addr_glb_psum   = bus.read_req_glb_psum ? col_addr : '0;
    assign bus.w_data_glb_psum   = !bus.write_en_glb_psum ? '0
                                 : (accum_first_reg ? buf_data : sum_reg);
`else
    logic unused_accum_inputs;
    assign unused_accum_inputs   = ^{bus.accum_first, bus.r_data_glb_psum};

    assign bus.read_req_glb_psum = 1'b0;
    assign bus.r_addr_glb_psum   = '0;
    assign bus.w_data_glb_psum   = bus.write_en_glb_psum ? buf_data : '0;
`endif

endmodule

// File: tb/tb_router_psum.sv
// Self-checking bench for router_psum: vector table, hand-written corner
// sequences and randomized iterations against a row/GLB reference model.
module tb_router_psum;
    import router_psum_pkg::*;

    localparam int XD = 3;
    localparam int NI = 3;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int GLB_DEPTH = 1 << AW;

    typedef logic [XD-1:0][DW-1:0] row_t;

    typedef struct {
        row_t pe;
        bit   af;
        row_t exp_d;
        int   base;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    bit   preload;

    router_psum_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .X_dim(XD)) ifc ();

    router_psum #(
        .DATA_BITWIDTH     (DW),
        .ADDR_BITWIDTH_GLB (AW),
        .X_dim             (XD),
        .NUM_ITER          (NI),
        .PSUM_LOAD_ADDR    (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // GLB bank seen by the DUT: registered read, one cycle latency.
    bit [DW-1:0] glb_mem [GLB_DEPTH];
    always @(posedge clk) begin
        if (preload) begin
            glb_mem[0] <= 16'd100;
            glb_mem[1] <= 16'd200;
            glb_mem[2] <= 16'd65535;
        end
        if (ifc.write_en_glb_psum) glb_mem[ifc.w_addr_glb_psum] <= ifc.w_data_glb_psum;
        if (ifc.read_req_glb_psum) ifc.r_data_glb_psum <= glb_mem[ifc.r_addr_glb_psum];
    end

    // Reference model: expected GLB contents and the current row index.
    bit [DW-1:0] glb_model [GLB_DEPTH];
    int model_iter = 0;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic row_t mk3(input psum_t c0, input psum_t c1, input psum_t c2);
        row_t r;
        r[0] = c0;
        r[1] = c1;
        r[2] = c2;
        return r;
    endfunction

    function automatic row_t model_data(input row_t pe, input bit af);
        row_t r;
        for (int k = 0; k < XD; k++) begin
`ifdef ROUTER_PSUM_ACCUM_EN
            r[k] = af ? pe[k] : DW'(glb_model[(model_iter * XD + k) % GLB_DEPTH] + pe[k]);
`else
            r[k] = pe[k];
`endif
        end
        return r;
    endfunction

    function automatic int wr_cycle(input int k);
`ifdef ROUTER_PSUM_ACCUM_EN
        return 3 * k + 3;
`else
        return k + 1;
`endif
    endfunction

    function automatic int done_cycle();
`ifdef ROUTER_PSUM_ACCUM_EN
        return 3 * XD + 1;
`else
        return XD + 1;
`endif
    endfunction

    // One compute_done edge and the resulting row write; cycles counted from the capture edge.
    task automatic do_iter(input row_t pe, input bit af, input row_t exp_d, input int base,
                           input int hold, input bit glitch, input string tag);
        int wr_j[$];
        int wr_a[$];
        int wr_d[$];
        int done_j = -1;
        int idle_j = -1;
        int n_done = 0;
        bit clash = 1'b0;
        @(negedge clk);
        ifc.pe_out       = pe;
        ifc.accum_first  = af;
        ifc.compute_done = 1'b1;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (ifc.write_en_glb_psum) begin
                wr_j.push_back(j);
                wr_a.push_back(int'(ifc.w_addr_glb_psum));
                wr_d.push_back(int'(ifc.w_data_glb_psum));
            end
            if (ifc.write_en_glb_psum && ifc.read_req_glb_psum) clash = 1'b1;
            if (ifc.write_done) begin
                n_done++;
                if (done_j < 0) done_j = j;
            end
            if (!ifc.busy && idle_j < 0) idle_j = j;
            if (j == hold) ifc.compute_done = 1'b0;
            if (glitch) begin
                if (j == 1) ifc.pe_out = ~pe;
                if (j == 2) ifc.compute_done = 1'b1;
                if (j == 3) ifc.compute_done = 1'b0;
            end
            if (idle_j >= 0 && j >= hold + 2) break;
        end
        ifc.compute_done = 1'b0;
        $display("iter %s base=%0d af=%0d writes=%0d done@%0d data=%0d,%0d,%0d",
                 tag, base, af, wr_j.size(), done_j, exp_d[0], exp_d[1], exp_d[2]);
        chk($sformatf("%s write count", tag), wr_j.size(), XD);
        for (int k = 0; k < XD; k++) begin
            if (k < wr_j.size()) begin
                chk($sformatf("%s col%0d cycle", tag, k), wr_j[k], wr_cycle(k));
                chk($sformatf("%s col%0d addr", tag, k), wr_a[k], (base + k) % GLB_DEPTH);
                chk($sformatf("%s col%0d data", tag, k), wr_d[k], int'(exp_d[k]));
            end
        end
        chk($sformatf("%s write_done cycle", tag), done_j, done_cycle());
        chk($sformatf("%s write_done pulses", tag), n_done, 1);
        chk($sformatf("%s busy drop cycle", tag), idle_j, done_cycle() + 1);
        chk($sformatf("%s write/read overlap", tag), clash, 0);
        for (int k = 0; k < XD; k++) glb_model[(base + k) % GLB_DEPTH] = exp_d[k];
        model_iter = (model_iter + 1) % NI;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " busy"}, ifc.busy, 0);
        chk({tag, " write_en"}, ifc.write_en_glb_psum, 0);
        chk({tag, " w_addr"}, ifc.w_addr_glb_psum, 0);
        chk({tag, " w_data"}, ifc.w_data_glb_psum, 0);
        chk({tag, " write_done"}, ifc.write_done, 0);
        chk({tag, " read_req"}, ifc.read_req_glb_psum, 0);
        chk({tag, " r_addr"}, ifc.r_addr_glb_psum, 0);
        chk({tag, " drop_err"}, ifc.drop_err, 0);
    endtask

    vec_t tbl[5];

    initial begin
        row_t pe;
        row_t ed;
        bit   af;
        int   base;
        int   nw;
        bit   hit;

`ifdef ROUTER_PSUM_ACCUM_EN
        tbl[0] = '{mk3(1, 2, 3), 1'b0, mk3(101, 202, 2), 0};
        tbl[1] = '{mk3(4, 5, 6), 1'b1, mk3(4, 5, 6), 3};
        tbl[2] = '{mk3(7, 8, 9), 1'b0, mk3(7, 8, 9), 6};
        tbl[3] = '{mk3(1, 2, 3), 1'b1, mk3(1, 2, 3), 0};
        tbl[4] = '{mk3(1, 1, 1), 1'b0, mk3(5, 6, 7), 3};
`else
        tbl[0] = '{mk3(5, 7, 9), 1'b0, mk3(5, 7, 9), 0};
        tbl[1] = '{mk3(16'hFFFF, 0, 16'h8000), 1'b1, mk3(16'hFFFF, 0, 16'h8000), 3};
        tbl[2] = '{mk3(1, 2, 3), 1'b0, mk3(1, 2, 3), 6};
        tbl[3] = '{mk3(10, 20, 30), 1'b1, mk3(10, 20, 30), 0};
        tbl[4] = '{mk3(4, 4, 4), 1'b0, mk3(4, 4, 4), 3};
`endif

        glb_model[0] = 16'd100;
        glb_model[1] = 16'd200;
        glb_model[2] = 16'd65535;

        reset            = 1'b1;
        preload          = 1'b1;
        ifc.pe_out       = '0;
        ifc.accum_first  = 1'b0;
        ifc.compute_done = 1'b0;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        chk_outputs_zero("reset");

        for (int i = 0; i < 5; i++) begin
            do_iter(tbl[i].pe, tbl[i].af, tbl[i].exp_d, tbl[i].base, 1, 1'b0, $sformatf("vec%0d", i));
        end

        // Level held high: only its rising edge counts.
        for (int k = 0; k < XD; k++) pe[k] = DW'($urandom);
        af = 1'($urandom_range(0, 1));
        ed = model_data(pe, af);
        do_iter(pe, af, ed, model_iter * XD, 10, 1'b0, "hold");
        chk("hold drop_err", ifc.drop_err, 0);

        // Second edge while busy: dropped, buffer untouched, error latched.
        for (int k = 0; k < XD; k++) pe[k] = DW'($urandom);
        af = 1'($urandom_range(0, 1));
        ed = model_data(pe, af);
        do_iter(pe, af, ed, model_iter * XD, 1, 1'b1, "glitch");
        chk("glitch drop_err set", ifc.drop_err, 1);

        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < XD; k++) pe[k] = DW'($urandom);
            af = 1'($urandom_range(0, 1));
            ed = model_data(pe, af);
            do_iter(pe, af, ed, model_iter * XD, 1, 1'b0, $sformatf("rand%0d", r));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        chk("drop_err sticky", ifc.drop_err, 1);

        // Reset during the col=1 write cycle.
        for (int k = 0; k < XD; k++) pe[k] = DW'($urandom);
        af   = 1'($urandom_range(0, 1));
        ed   = model_data(pe, af);
        base = model_iter * XD;
        nw   = 0;
        hit  = 1'b0;
        @(negedge clk);
        ifc.pe_out       = pe;
        ifc.accum_first  = af;
        ifc.compute_done = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (j == 1) ifc.compute_done = 1'b0;
            if (ifc.write_en_glb_psum) begin
                nw++;
                if (nw == 2) begin
                    reset = 1'b1;
                    #1;
                    hit = 1'b1;
                    chk_outputs_zero("rstmid");
                    break;
                end
            end
        end
        chk("rstmid reached col1 write", hit, 1);
        $display("iter rstmid base=%0d af=%0d aborted after col0", base, af);
        @(negedge clk);
        reset = 1'b0;
        nw = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (ifc.write_en_glb_psum || ifc.busy) nw++;
        end
        chk("rstmid activity after release", nw, 0);
        glb_model[base] = ed[0];
        model_iter = 0;

        for (int k = 0; k < XD; k++) pe[k] = DW'($urandom);
        af = 1'($urandom_range(0, 1));
        ed = model_data(pe, af);
        do_iter(pe, af, ed, 0, 1, 1'b0, "post_reset");
        chk("post_reset drop_err", ifc.drop_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/router_psum.md
# router_psum

Downstream stage of the PE cluster. Captures the per-column partial sums produced at the end of each compute iteration and writes them serially into the psum GLB bank. Addresses advance one row per iteration. Optionally performs read-modify-write accumulation into the GLB instead of overwriting.

## Interface
Parameters:
- DATA_BITWIDTH, 16, width of a psum word
- ADDR_BITWIDTH_GLB, 10, psum GLB address width
- X_dim, 3, number of PE columns (psums per iteration)
- NUM_ITER, 3, iterations per pass; row index wraps after NUM_ITER
- PSUM_LOAD_ADDR, 0, GLB base address of row 0

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- pe_out  in  [X_dim] x DATA_BITWIDTH  PE cluster column psums
- compute_done  in  1  level from PE cluster; rising edge marks valid pe_out
- accum_first  in  1  sampled at capture; 1 = overwrite (accumulation build only)
- write_en_glb_psum  out  1  GLB write strobe
- w_addr_glb_psum  out  ADDR_BITWIDTH_GLB  GLB write address
- w_data_glb_psum  out  DATA_BITWIDTH  GLB write data
- read_req_glb_psum  out  1  GLB read request (accumulation build only; otherwise tied 0)
- r_addr_glb_psum  out  ADDR_BITWIDTH_GLB  GLB read address
- r_data_glb_psum  in  DATA_BITWIDTH  GLB read data, valid the cycle after read_req
- busy  out  1  high while not IDLE
- write_done  out  1  one-cycle pulse after the last column is written
- drop_err  out  1  sticky; set when a compute_done edge arrives while busy

## Operation
- Register compute_done. A rising edge is one where the current value is 1 and the previous value was 0.
- In IDLE, a rising edge copies all pe_out into the column buffer, latches accum_first, clears col, and enters the write sequence.
- Address = PSUM_LOAD_ADDR + iter*X_dim + col, truncated to ADDR_BITWIDTH_GLB.
- States without accumulation: IDLE -> WRITE (X_dim cycles, col 0..X_dim-1) -> DONE -> IDLE.
- States with accumulation: IDLE -> READ -> WAIT -> WRITE, repeated per column -> DONE -> IDLE.
  - READ: assert read_req at the column address.
  - WAIT: register sum = r_data + buf[col].
  - WRITE: write the sum. If accum_first=1, write buf[col] instead.
- DONE: pulse write_done. iter increments and wraps from NUM_ITER-1 to 0.
- Sums wrap modulo 2^DATA_BITWIDTH. No saturation.
- A compute_done edge while busy is ignored. The buffer is not overwritten and drop_err is set.
- Reset value of every output and internal register is 0. State is IDLE, iter=0, col=0, drop_err=0.
- Reset asserted mid-sequence aborts immediately. No partial write follows reset deassertion.

## Timing
- Edge sampled at clock edge N: capture at N, first state cycle is N+1.
- Without accumulation: write_en high for cycles N+1..N+X_dim, one column per cycle. write_done pulses in cycle N+X_dim+1. busy drops in cycle N+X_dim+2.
- With accumulation: three cycles per column. Write of col k occurs in cycle N+3k+3. write_done pulses in cycle N+3*X_dim+1.
- write_en and read_req are never high in the same cycle.
- Minimum spacing between accepted compute_done edges is X_dim+2 cycles (non-accumulating build).

## Configuration
- ROUTER_PSUM_ACCUM_EN defined: read-modify-write path is compiled in (READ/WAIT states, read port active, accum_first honoured).
- ROUTER_PSUM_ACCUM_EN undefined: plain overwrite only. read_req_glb_psum and r_addr_glb_psum are driven 0, and accum_first and r_data are ignored.

## Structure
- Package router_psum_pkg holds the state enum (IDLE, READ, WAIT, WRITE, DONE) and a psum_t typedef of DATA_BITWIDTH.
- One sub-module, psum_capture_buf: X_dim-entry register array with load-all and indexed read.

## Test plan
All scenarios use X_dim=3 and PSUM_LOAD_ADDR=0.
- Non-accum, pe_out={5,7,9}, one compute_done edge -> writes (0,5),(1,7),(2,9) on consecutive cycles, then a write_done pulse.
- Three iterations -> rows written at addresses 0-2, 3-5 and 6-8. A fourth iteration wraps to address 0.
- compute_done held high for 10 cycles -> exactly one write sequence.
- Second compute_done edge during WRITE -> ignored, drop_err=1 until reset, and written data unchanged.
- ACCUM_EN, GLB[0..2]={100,200,65535}, pe_out={1,2,3}, accum_first=0 -> writes 101, 202, 2 (wrap). With accum_first=1 -> writes 1, 2, 3.
- Reset asserted in the cycle of the col=1 write -> all outputs 0 next cycle, no further writes, and iter=0 on the next edge.
